// File: rtl/sysop_issue.sv
// sysop_issue
// -----------
// Issue sequencer for RISC-V SYSTEM instructions. This is the initiator side
// of the exception/CSR unit's sysop interface. It takes one decoded-stage
// instruction at a time and decodes ECALL, MRET and the six Zicsr forms. It
// drives cause/pc/data1/tval for exactly one cycle, then collects the result:
// the old CSR value goes to the register file, and a trap/return becomes a
// fetch redirect.
//
// Handshake: an instruction transfers on a rising edge where in_valid and
// in_ready are both high. in_ready is high only in IDLE. The upstream stage
// holds its inputs stable while in_valid is high and in_ready is low.
// Illegal words are still accepted. They produce an illegal pulse and
// nothing is issued.
//
// Ports
//   clk, rst_n                 clock, asynchronous active-low reset
//   in_valid/in_ready          instruction handshake
//   in_pc, in_instr            instruction PC and word
//   in_rs1_data                rs1 register value
//   cause, pc, data1, tval     request to the exception unit (cause=0 idle)
//   csr_data                   old CSR value (combinational from the unit)
//   trap_en, trap_pc           trap/return taken and its target
//   rd_we, rd_addr, rd_data    one-cycle register-file write of the old CSR value
//   redirect_en, redirect_pc   one-cycle fetch redirect
//   illegal                    one-cycle illegal/unsupported/timeout pulse
//   busy                       not IDLE
//   dbg_state                  current FSM state (IDLE=0, ISSUE=1, WAIT=2)
module sysop_issue #(
    parameter int TRAP_TIMEOUT = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [63:0] in_pc,
    input  logic [31:0] in_instr,
    input  logic [63:0] in_rs1_data,
    output logic [4:0]  cause,
    output logic [63:0] pc,
    output logic [63:0] data1,
    output logic [63:0] tval,
    input  logic [63:0] csr_data,
    input  logic        trap_en,
    input  logic [63:0] trap_pc,
    output logic        rd_we,
    output logic [4:0]  rd_addr,
    output logic [63:0] rd_data,
    output logic        redirect_en,
    output logic [63:0] redirect_pc,
    output logic        illegal,
    output logic        busy,
    output logic [1:0]  dbg_state
);

    // Sysop encodings shared with the exception unit.
    localparam logic [4:0] SYSOP_NONE  = 5'd0;
    localparam logic [4:0] SYSOP_CSR_W = 5'd1;
    localparam logic [4:0] SYSOP_CSR_S = 5'd2;
    localparam logic [4:0] SYSOP_CSR_C = 5'd3;
    localparam logic [4:0] SYSOP_ECALL = 5'd4;
    localparam logic [4:0] SYSOP_RET   = 5'd5;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ISSUE = 2'd1;
    localparam logic [1:0] S_WAIT  = 2'd2;

    localparam logic [31:0] ECALL_WORD = 32'h0000_0073;
    localparam logic [31:0] MRET_WORD  = 32'h3020_0073;

    localparam int          CW        = (TRAP_TIMEOUT > 1) ? $clog2(TRAP_TIMEOUT) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(TRAP_TIMEOUT - 1);

    logic [1:0]    state;
    logic [CW-1:0] cnt;
    logic [4:0]    rd_q;
    logic          csr_op_q;

    // Decode of the offered word.
    logic [2:0]  f3;
    logic        dec_legal;
    logic        dec_csr;
    logic [4:0]  dec_cause;
    logic [63:0] dec_data1;
    logic [63:0] dec_tval;

    assign f3 = in_instr[14:12];

    always_comb begin
        dec_legal = 1'b0;
        dec_csr   = 1'b0;
        dec_cause = SYSOP_NONE;
        dec_data1 = 64'd0;
        dec_tval  = 64'd0;
        if (in_instr == ECALL_WORD) begin
            dec_legal = 1'b1;
            dec_cause = SYSOP_ECALL;
        end else if (in_instr == MRET_WORD) begin
            dec_legal = 1'b1;
            dec_cause = SYSOP_RET;
        end else if (in_instr[6:0] == 7'h73 && f3 != 3'd0 && f3 != 3'd4) begin
            dec_legal = 1'b1;
            dec_csr   = 1'b1;
            dec_tval  = {52'd0, in_instr[31:20]};
            // funct3[2] selects the zimm form; funct3[1:0] picks W/S/C.
            dec_data1 = f3[2] ? {59'd0, in_instr[19:15]} : in_rs1_data;
            case (f3[1:0])
                2'd1:    dec_cause = SYSOP_CSR_W;
                2'd2:    dec_cause = SYSOP_CSR_S;
                default: dec_cause = SYSOP_CSR_C;
            endcase
        end
    end

    assign in_ready  = (state == S_IDLE);
    assign busy      = (state != S_IDLE);
    assign dbg_state = state;

    // cause is a register that is cleared on leaving ISSUE. It is therefore
    // nonzero for exactly the ISSUE cycle, and an asynchronous reset clears
    // it immediately.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= S_IDLE;
            cnt         <= '0;
            cause       <= SYSOP_NONE;
            pc          <= 64'd0;
            data1       <= 64'd0;
            tval        <= 64'd0;
            rd_q        <= 5'd0;
            csr_op_q    <= 1'b0;
            rd_we       <= 1'b0;
            rd_addr     <= 5'd0;
            rd_data     <= 64'd0;
            redirect_en <= 1'b0;
            redirect_pc <= 64'd0;
            illegal     <= 1'b0;
        end else begin
            rd_we       <= 1'b0;
            redirect_en <= 1'b0;
            illegal     <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (in_valid) begin
                        if (dec_legal) begin
                            cause    <= dec_cause;
                            pc       <= in_pc;
                            data1    <= dec_data1;
                            tval     <= dec_tval;
                            rd_q     <= in_instr[11:7];
                            csr_op_q <= dec_csr;
                            state    <= S_ISSUE;
                        end else begin
                            illegal <= 1'b1;
                        end
                    end
                end
                S_ISSUE: begin
                    cause <= SYSOP_NONE;
                    if (csr_op_q) begin
                        rd_data <= csr_data;
                        rd_addr <= rd_q;
                        rd_we   <= (rd_q != 5'd0);
                        state   <= S_IDLE;
                    end else begin
                        cnt   <= '0;
                        state <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (trap_en) begin
                        redirect_en <= 1'b1;
                        redirect_pc <= trap_pc;
                        state       <= S_IDLE;
                    end else if (cnt == CNT_LAST) begin
                        // The exception unit never answered: report it as illegal.
                        illegal <= 1'b1;
                        state   <= S_IDLE;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sysop_issue.sv
module tb_sysop_issue;

    localparam int TRAP_TIMEOUT = 4;

    localparam logic [4:0] C_NONE  = 5'd0;
    localparam logic [4:0] C_CSR_W = 5'd1;
    localparam logic [4:0] C_CSR_S = 5'd2;
    localparam logic [4:0] C_CSR_C = 5'd3;
    localparam logic [4:0] C_ECALL = 5'd4;
    localparam logic [4:0] C_RET   = 5'd5;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [63:0] in_pc = 64'd0;
    logic [31:0] in_instr = 32'd0;
    logic [63:0] in_rs1_data = 64'd0;
    logic [4:0]  cause;
    logic [63:0] pc, data1, tval;
    logic [63:0] csr_data = 64'd0;
    logic        trap_en = 1'b0;
    logic [63:0] trap_pc = 64'd0;
    logic        rd_we;
    logic [4:0]  rd_addr;
    logic [63:0] rd_data;
    logic        redirect_en;
    logic [63:0] redirect_pc;
    logic        illegal;
    logic        busy;
    logic [1:0]  dbg_state;

    int checks = 0;
    int errors = 0;

    // Expected register-file writes: {rd, data}.
    logic [68:0] exp_q[$];

    sysop_issue #(.TRAP_TIMEOUT(TRAP_TIMEOUT)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_pc(in_pc), .in_instr(in_instr), .in_rs1_data(in_rs1_data),
        .cause(cause), .pc(pc), .data1(data1), .tval(tval),
        .csr_data(csr_data), .trap_en(trap_en), .trap_pc(trap_pc),
        .rd_we(rd_we), .rd_addr(rd_addr), .rd_data(rd_data),
        .redirect_en(redirect_en), .redirect_pc(redirect_pc),
        .illegal(illegal), .busy(busy), .dbg_state(dbg_state)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- reference model ----------------
    // Cause the specification assigns to an instruction word (0 = not issued).
    function automatic logic [4:0] ref_cause(input logic [31:0] w);
        logic [2:0] fn;
        fn = w[14:12];
        if (w == 32'h0000_0073) return C_ECALL;
        if (w == 32'h3020_0073) return C_RET;
        if (w[6:0] != 7'h73) return C_NONE;
        if (fn == 3'd1 || fn == 3'd5) return C_CSR_W;
        if (fn == 3'd2 || fn == 3'd6) return C_CSR_S;
        if (fn == 3'd3 || fn == 3'd7) return C_CSR_C;
        return C_NONE;
    endfunction

    function automatic logic is_csr(input logic [4:0] c);
        return (c == C_CSR_W) || (c == C_CSR_S) || (c == C_CSR_C);
    endfunction

    function automatic logic [63:0] ref_data1(input logic [31:0] w, input logic [63:0] r);
        if (!is_csr(ref_cause(w))) return 64'd0;
        if (w[14:12] >= 3'd5) return 64'(w[19:15]);
        return r;
    endfunction

    function automatic logic [63:0] ref_tval(input logic [31:0] w);
        if (!is_csr(ref_cause(w))) return 64'd0;
        return 64'(w[31:20]);
    endfunction

    function automatic logic [31:0] rand_csr_word();
        logic [2:0] fn;
        int sel;
        sel = $urandom_range(0, 5);
        fn  = (sel < 3) ? 3'(sel + 1) : 3'(sel + 2);
        return {12'($urandom), 5'($urandom), fn, 5'($urandom), 7'h73};
    endfunction

    // ---------------- driver ----------------
    // Offers one instruction and returns just after the accepting edge.
    task automatic accept(input logic [31:0] w, input logic [63:0] p, input logic [63:0] r);
        @(negedge clk);
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL accept_ready: in_ready=%b expected 1", in_ready);
        end
        in_valid    = 1'b1;
        in_instr    = w;
        in_pc       = p;
        in_rs1_data = r;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if (cause !== 5'd0 || in_ready !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_ctrl: cause=%0d in_ready=%b busy=%b expected 0/1/0", cause, in_ready, busy);
        end
        checks++;
        if ({rd_we, redirect_en, illegal} !== 3'b000) begin
            errors++;
            $display("FAIL reset_strobes: rd_we/redirect/illegal=%b expected 000", {rd_we, redirect_en, illegal});
        end
        checks++;
        if (pc !== 64'd0 || data1 !== 64'd0 || tval !== 64'd0 || rd_data !== 64'd0 ||
            redirect_pc !== 64'd0 || rd_addr !== 5'd0) begin
            errors++;
            $display("FAIL reset_data: pc=%h data1=%h tval=%h rd_data=%h rpc=%h rd_addr=%0d expected all 0",
                     pc, data1, tval, rd_data, redirect_pc, rd_addr);
        end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_csr_directed();
        // csrrw x0, mepc, x2
        accept(32'h3411_1073, 64'h2000, 64'h8000_0040);
        @(negedge clk);
        checks++;
        if (cause !== C_CSR_W || tval !== 64'h341 || data1 !== 64'h8000_0040 || pc !== 64'h2000) begin
            errors++;
            $display("FAIL csrrw_issue: cause=%0d tval=%h data1=%h pc=%h expected %0d/341/80000040/2000",
                     cause, tval, data1, pc, C_CSR_W);
        end
        csr_data = 64'h1234;
        @(posedge clk);
        @(negedge clk);
        checks++;
        if (rd_we !== 1'b0 || cause !== 5'd0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL csrrw_done: rd_we=%b cause=%0d in_ready=%b expected 0/0/1", rd_we, cause, in_ready);
        end
        // csrrsi x10, mstatus, 8 offered in the very next cycle
        in_valid = 1'b1;
        in_instr = 32'h3004_6573;
        in_pc    = 64'h2004;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (cause !== C_CSR_S || data1 !== 64'd8 || tval !== 64'h300) begin
            errors++;
            $display("FAIL csrrsi_issue: cause=%0d data1=%h tval=%h expected %0d/8/300", cause, data1, tval, C_CSR_S);
        end
        csr_data = 64'hA;
        @(posedge clk);
        @(negedge clk);
        checks++;
        if (rd_we !== 1'b1 || rd_addr !== 5'd10 || rd_data !== 64'hA) begin
            errors++;
            $display("FAIL csrrsi_wb: rd_we=%b rd_addr=%0d rd_data=%h expected 1/10/a", rd_we, rd_addr, rd_data);
        end
        @(negedge clk);
        checks++;
        if (rd_we !== 1'b0) begin
            errors++;
            $display("FAIL csrrsi_pulse: rd_we=%b expected 0", rd_we);
        end
    endtask

    // Random CSR ops streamed at the maximum rate of one per two cycles.
    task automatic test_back_to_back();
        localparam int N = 24;
        logic [31:0] w_cur, w_nxt;
        logic [63:0] r_cur, r_nxt, p_cur, p_nxt, c_val;
        logic [68:0] e;
        logic        exp_we;
        w_cur = rand_csr_word();
        r_cur = {$urandom, $urandom};
        p_cur = 64'({$urandom} & 32'hFFFF_FFFC);
        @(negedge clk);
        in_valid = 1'b1; in_instr = w_cur; in_rs1_data = r_cur; in_pc = p_cur;
        for (int i = 0; i < N; i++) begin
            @(posedge clk);
            @(negedge clk);
            checks++;
            if (cause !== ref_cause(w_cur) || data1 !== ref_data1(w_cur, r_cur) ||
                tval !== ref_tval(w_cur) || pc !== p_cur || in_ready !== 1'b0) begin
                errors++;
                $display("FAIL b2b_issue[%0d]: cause=%0d data1=%h tval=%h pc=%h rdy=%b expected %0d/%h/%h/%h/0",
                         i, cause, data1, tval, pc, in_ready, ref_cause(w_cur),
                         ref_data1(w_cur, r_cur), ref_tval(w_cur), p_cur);
            end
            c_val    = {$urandom, $urandom};
            csr_data = c_val;
            exp_we   = (w_cur[11:7] != 5'd0);
            if (exp_we) exp_q.push_back({w_cur[11:7], c_val});
            w_nxt = rand_csr_word();
            r_nxt = {$urandom, $urandom};
            p_nxt = 64'({$urandom} & 32'hFFFF_FFFC);
            in_valid = (i < N - 1); in_instr = w_nxt; in_rs1_data = r_nxt; in_pc = p_nxt;
            @(posedge clk);
            @(negedge clk);
            checks++;
            if (in_ready !== 1'b1 || rd_we !== exp_we) begin
                errors++;
                $display("FAIL b2b_wb[%0d]: in_ready=%b rd_we=%b expected 1/%b", i, in_ready, rd_we, exp_we);
            end else if (rd_we) begin
                e = exp_q.pop_front();
                checks++;
                if (rd_addr !== e[68:64] || rd_data !== e[63:0]) begin
                    errors++;
                    $display("FAIL b2b_rd[%0d]: rd_addr=%0d rd_data=%h expected %0d/%h",
                             i, rd_addr, rd_data, e[68:64], e[63:0]);
                end
            end
            w_cur = w_nxt; r_cur = r_nxt; p_cur = p_nxt;
        end
        in_valid = 1'b0;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL b2b_leftover: %0d expected writes missing, expected 0", exp_q.size());
        end
    endtask

    task automatic test_ecall();
        accept(32'h0000_0073, 64'h1000, {$urandom, $urandom});
        @(negedge clk);
        checks++;
        if (cause !== C_ECALL || pc !== 64'h1000 || data1 !== 64'd0 || tval !== 64'd0) begin
            errors++;
            $display("FAIL ecall_issue: cause=%0d pc=%h data1=%h tval=%h expected %0d/1000/0/0",
                     cause, pc, data1, tval, C_ECALL);
        end
        @(negedge clk);
        trap_en = 1'b1;
        trap_pc = 64'h8000_0000;
        checks++;
        if (cause !== 5'd0 || busy !== 1'b1 || redirect_en !== 1'b0) begin
            errors++;
            $display("FAIL ecall_wait: cause=%0d busy=%b redirect=%b expected 0/1/0", cause, busy, redirect_en);
        end
        @(negedge clk);
        trap_en = 1'b0;
        checks++;
        if (redirect_en !== 1'b1 || redirect_pc !== 64'h8000_0000 || in_ready !== 1'b1 || illegal !== 1'b0) begin
            errors++;
            $display("FAIL ecall_redirect: en=%b pc=%h in_ready=%b illegal=%b expected 1/80000000/1/0",
                     redirect_en, redirect_pc, in_ready, illegal);
        end
        @(negedge clk);
        checks++;
        if (redirect_en !== 1'b0) begin
            errors++;
            $display("FAIL ecall_pulse: redirect_en=%b expected 0", redirect_en);
        end
    endtask

    // ECALL/MRET answered after a random number of WAIT cycles inside the window.
    task automatic test_trap_random();
        for (int n = 0; n < 6; n++) begin
            int k;
            logic [31:0] w;
            logic [63:0] tp;
            k  = $urandom_range(0, TRAP_TIMEOUT - 1);
            w  = $urandom_range(0, 1) ? 32'h0000_0073 : 32'h3020_0073;
            tp = {$urandom, $urandom};
            accept(w, {$urandom, $urandom}, 64'd0);
            for (int c = 1; c <= k + 3; c++) begin
                @(negedge clk);
                trap_en = (c == 2 + k);
                trap_pc = tp;
                checks++;
                if (redirect_en !== (c == 3 + k) || illegal !== 1'b0 || cause !== ((c == 1) ? ref_cause(w) : C_NONE)) begin
                    errors++;
                    $display("FAIL trap_rand[%0d] cycle %0d: redirect=%b illegal=%b cause=%0d expected %b/0/%0d",
                             n, c, redirect_en, illegal, cause, (c == 3 + k), (c == 1) ? ref_cause(w) : C_NONE);
                end
                if (c == 3 + k) begin
                    checks++;
                    if (redirect_pc !== tp) begin
                        errors++;
                        $display("FAIL trap_rand_pc[%0d]: redirect_pc=%h expected %h", n, redirect_pc, tp);
                    end
                end
            end
            trap_en = 1'b0;
        end
    endtask

    task automatic test_mret_timeout();
        int seen;
        seen = 0;
        accept(32'h3020_0073, 64'h3000, 64'd0);
        for (int c = 1; c <= 12; c++) begin
            @(negedge clk);
            if (c == 1) begin
                checks++;
                if (cause !== C_RET) begin
                    errors++;
                    $display("FAIL mret_issue: cause=%0d expected %0d", cause, C_RET);
                end
            end
            checks++;
            if (redirect_en !== 1'b0 || rd_we !== 1'b0) begin
                errors++;
                $display("FAIL mret_strobe cycle %0d: redirect=%b rd_we=%b expected 0/0", c, redirect_en, rd_we);
            end
            if (illegal === 1'b1) begin
                seen = c;
                break;
            end
        end
        checks++;
        if (seen != TRAP_TIMEOUT + 2) begin
            errors++;
            $display("FAIL mret_timeout: illegal in cycle %0d expected %0d", seen, TRAP_TIMEOUT + 2);
        end
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL mret_ready: in_ready=%b expected 1", in_ready);
        end
    endtask

    task automatic test_unsupported();
        logic [31:0] words[6];
        logic [31:0] rw;
        words[0] = 32'h0010_0073;  // EBREAK
        words[1] = 32'h0000_0013;  // addi x0,x0,0
        words[2] = 32'h1050_0073;  // WFI
        words[3] = {12'h300, 5'd1, 3'd4, 5'd5, 7'h73};
        rw = $urandom;
        if (rw[6:0] == 7'h73) rw[0] = 1'b0;
        words[4] = rw;
        words[5] = {17'($urandom), 3'd4, 5'($urandom), 7'h73};
        foreach (words[i]) begin
            accept(words[i], 64'h4000, 64'd1);
            @(negedge clk);
            checks++;
            if (illegal !== 1'b1 || cause !== 5'd0 || busy !== 1'b0 || in_ready !== 1'b1) begin
                errors++;
                $display("FAIL unsupported[%0d] %h: illegal=%b cause=%0d busy=%b rdy=%b expected 1/0/0/1",
                         i, words[i], illegal, cause, busy, in_ready);
            end
            @(negedge clk);
            checks++;
            if (illegal !== 1'b0 || cause !== 5'd0) begin
                errors++;
                $display("FAIL unsupported_pulse[%0d]: illegal=%b cause=%0d expected 0/0", i, illegal, cause);
            end
        end
    endtask

    task automatic test_trap_idle();
        @(negedge clk);
        trap_en = 1'b1;
        trap_pc = 64'hDEAD;
        repeat (2) @(negedge clk);
        checks++;
        if (redirect_en !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL trap_idle: redirect=%b busy=%b expected 0/0", redirect_en, busy);
        end
        trap_en = 1'b0;
    endtask

    task automatic test_reset_mid_issue();
        // csrrs x5, mstatus, x1
        accept({12'h300, 5'd1, 3'd2, 5'd5, 7'h73}, 64'h5000, 64'hFF);
        @(negedge clk);
        csr_data = 64'h77;
        checks++;
        if (cause !== C_CSR_S) begin
            errors++;
            $display("FAIL rst_issue_pre: cause=%0d expected %0d", cause, C_CSR_S);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if (cause !== 5'd0 || busy !== 1'b0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL rst_issue_async: cause=%0d busy=%b rdy=%b expected 0/0/1", cause, busy, in_ready);
        end
        @(negedge clk);
        checks++;
        if (rd_we !== 1'b0 || illegal !== 1'b0 || redirect_en !== 1'b0) begin
            errors++;
            $display("FAIL rst_issue_strobe: rd_we=%b illegal=%b redirect=%b expected 000", rd_we, illegal, redirect_en);
        end
        rst_n = 1'b1;
        // Reset during WAIT: the pending trap must not produce a redirect.
        accept(32'h0000_0073, 64'h6000, 64'd0);
        @(negedge clk);
        @(negedge clk);
        trap_en = 1'b1;
        trap_pc = 64'h9000;
        rst_n = 1'b0;
        #1;
        checks++;
        if (cause !== 5'd0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL rst_wait_async: cause=%0d busy=%b expected 0/0", cause, busy);
        end
        @(negedge clk);
        trap_en = 1'b0;
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (redirect_en !== 1'b0 || illegal !== 1'b0) begin
            errors++;
            $display("FAIL rst_wait_strobe: redirect=%b illegal=%b expected 0/0", redirect_en, illegal);
        end
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        test_reset();
        test_csr_directed();
        test_back_to_back();
        test_ecall();
        test_trap_random();
        test_mret_timeout();
        test_unsupported();
        test_trap_idle();
        test_reset_mid_issue();
        repeat (2) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/sysop_issue.md
# sysop_issue

Issue sequencer for RISC-V SYSTEM instructions, the initiator side of the exception/CSR unit's sysop interface. It accepts one decoded-stage instruction at a time over a valid/ready handshake and decodes ECALL, MRET and the six Zicsr forms. It drives the exception unit's `cause`/`pc`/`data1`/`tval` inputs for exactly one cycle, then collects the result: old CSR value to the register file, or `trap_en`/`trap_pc` into a fetch redirect.

## Interface
- TRAP_TIMEOUT, 4: WAIT cycles allowed for `trap_en` before the request is abandoned as illegal.
- clk  in  1  clock.
- rst_n  in  1  reset, asynchronous, active-low.
- in_valid  in  1  instruction offered.
- in_ready  out  1  `state==IDLE`.
- in_pc  in  64  instruction PC.
- in_instr  in  32  instruction word.
- in_rs1_data  in  64  rs1 register value.
- cause  out  5  sysop code to the exception unit (csr.vh SYSOP_* encodings). Idle value is 5'd0.
- pc  out  64  PC to the exception unit.
- data1  out  64  operand to the exception unit.
- tval  out  64  CSR address, zero-extended.
- csr_data  in  64  old CSR value, combinational from the exception unit.
- trap_en  in  1  trap/return taken, registered in the exception unit.
- trap_pc  in  64  target PC.
- rd_we  out  1  one-cycle register-file write strobe.
- rd_addr  out  5  destination register.
- rd_data  out  64  old CSR value.
- redirect_en  out  1  one-cycle fetch redirect.
- redirect_pc  out  64  redirect target.
- illegal  out  1  one-cycle illegal/unsupported pulse.
- busy  out  1  `state!=IDLE`.

## Operation
- **Field slices:** opcode=[6:0], rd=[11:7], funct3=[14:12], rs1/zimm=[19:15], csr=[31:20].
- **ECALL:** 0x00000073 → SYSOP_ECALL. `data1=0`, `tval=0`.
- **MRET:** 0x30200073 → SYSOP_RET. `data1=0`, `tval=0`.
- **Register CSR forms:** funct3 1/2/3 → CSR_W/CSR_S/CSR_C. `data1=in_rs1_data`.
- **Immediate CSR forms:** funct3 5/6/7 → same causes. `data1={59'b0,zimm}`.
- **CSR ops:** `tval={52'b0,csr}`.
- **Illegal:** any other word (opcode≠0x73, funct3=4, EBREAK, other funct3=0 immediates) is still accepted but nothing is issued.
- **Registered fields:** captured into registers on accept; `cause`/`pc`/`data1`/`tval` come from registers, never combinationally from inputs.
- **FSM states:** IDLE, ISSUE, WAIT.
- **IDLE:**
  - On `in_valid & in_ready`, capture the fields.
  - Legal instruction → ISSUE.
  - Illegal instruction → `illegal<=1`, stay in IDLE.
- **ISSUE:** `cause` = decoded code for exactly this one cycle.
  - CSR op: `rd_data<=csr_data`, `rd_addr<=rd`, `rd_we<=(rd!=0)`. Next state IDLE.
  - ECALL/RET: clear the timeout counter. Next state WAIT.
- **WAIT:** `cause=0`.
  - If `trap_en`: `redirect_en<=1`, `redirect_pc<=trap_pc`, next state IDLE.
  - Else increment the counter. When the counter reaches TRAP_TIMEOUT-1 without `trap_en`: `illegal<=1`, next state IDLE, no redirect.
- **Operand outputs outside ISSUE:** `pc`/`data1`/`tval` keep their last captured values. `cause=0` guarantees the exception unit ignores them.
- **CSRRS/CSRRC with rs1=x0:** still issued; OR/AND-NOT with 0 leaves the CSR unchanged.
- **`trap_en` outside WAIT:** ignored.

## Timing
- **Reset:** state IDLE, counter 0. All outputs 0 except `in_ready=1`. `cause` returns to 0 asynchronously on reset assertion, including mid-ISSUE or mid-WAIT; no pending strobe survives.
- **CSR op** accepted at edge T:
  - ISSUE during cycle T..T+1 (`cause` valid).
  - `rd_we` high for cycle T+1..T+2. `in_ready` is high again in that same cycle, so back-to-back CSR ops sustain one per 2 cycles.
- **ECALL/RET** accepted at edge T:
  - ISSUE in cycle 1.
  - WAIT in cycle 2, where `trap_en` is observed.
  - `redirect_en` high in cycle 3. `in_ready` is high in cycle 3.
  - Upstream must squash younger instructions on `redirect_en`.
- **Illegal:** `illegal` high in cycle 1 after accept. `in_ready` stays 1.
- **Pulse outputs:** `rd_we`, `redirect_en` and `illegal` are single-cycle pulses, mutually exclusive.

## Test plan
- **Reset:** hold `rst_n=0` → `cause=0`, `in_ready=1`, all strobes 0. Assert reset during ISSUE → `cause` drops to 0 immediately, no `rd_we`.
- **CSRRW:** `in_instr=0x34111073` (csrrw x0,mepc,x2), `in_rs1_data=0x8000_0040` → one cycle of `cause=CSR_W`, `tval=0x341`, `data1=0x80000040`. No `rd_we` (rd=0). Second instruction accepted in the following cycle.
- **CSRRSI:** `in_instr=0x30046573` (csrrsi x10,mstatus,8), stub `csr_data=0xA` → `data1=8`, `cause=CSR_S`. Next cycle `rd_we=1`, `rd_addr=10`, `rd_data=0xA`.
- **ECALL:** `in_instr=0x00000073`, `in_pc=0x1000`, stub returns `trap_en=1`, `trap_pc=0x8000_0000` one cycle after ISSUE → `cause=ECALL`, `pc=0x1000`. `redirect_en=1`, `redirect_pc=0x80000000` exactly 3 cycles after accept.
- **MRET timeout:** `in_instr=0x30200073`, stub never asserts `trap_en` → `illegal` pulses after TRAP_TIMEOUT WAIT cycles, no redirect, `in_ready` returns to 1.
- **Unsupported:** `in_instr=0x00100073` (EBREAK) and `0x00000013` → `illegal` one cycle after accept, `cause` stays 0, `busy` stays 0.
